// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified RAM port arbiter and its latency counter.
package mem_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;
    localparam int   CNT_W   = 4;

    // Tie-break alternates against whoever won last so neither side starves.
    function automatic logic pick_owner(
        input logic cand_if,
        input logic cand_mem,
        input logic last_owner
    );
        logic own;
        if (cand_mem && cand_if) begin
            own = (last_owner == OWN_MEM) ? OWN_IF : OWN_MEM;
        end else if (cand_mem) begin
            own = OWN_MEM;
        end else begin
            own = OWN_IF;
        end
        return own;
    endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Down-counter tracking an outstanding fixed-latency access; flags the final cycle.
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins over decrement; saturates at zero instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM port between IF fetches and MEM loads/stores, tracking read latency
// and returning done/rdata to the winner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_wdata,
    input  logic [3:0]    mem_wstrb,
    output logic          mem_done,
    output logic [31:0]   mem_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    output logic [3:0]    ram_wstrb,
    input  logic [31:0]   ram_rdata,
    output logic          stall
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY);

    state_e state_q;
    state_e state_d;
    logic   owner_q;
    logic   owner_d;
    logic   last_owner_q;
    logic   last_owner_d;
    logic   squash_q;
    logic   squash_d;

    logic   cand_if_s;
    logic   cand_mem_s;
    logic   winner_s;
    logic   cnt_load_s;
    logic   cnt_dec_s;
    logic   cnt_last_s;

    mem_lat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load_s),
        .load_val_i(LAT_LOAD),
        .dec_i     (cnt_dec_s),
        .last_o    (cnt_last_s)
    );

    assign cand_if_s  = if_req && !flush;
    assign cand_mem_s = mem_req;
    assign winner_s   = pick_owner(cand_if_s, cand_mem_s, last_owner_q);

    // Next-state, grant and response decode; everything forced low while in reset.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        squash_d     = squash_q;
        cnt_load_s   = 1'b0;
        cnt_dec_s    = 1'b0;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = 32'h0000_0000;
        ram_wstrb    = 4'h0;
        if_done      = 1'b0;
        if_rdata     = 32'h0000_0000;
        mem_done     = 1'b0;
        mem_rdata    = 32'h0000_0000;
        stall        = 1'b0;

        if (rst) begin
            state_d  = ST_IDLE;
            squash_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cand_if_s || cand_mem_s) begin
                        ram_en       = 1'b1;
                        last_owner_d = winner_s;
                        if (winner_s == OWN_MEM) begin
                            ram_we    = mem_we;
                            ram_addr  = mem_addr;
                            ram_wdata = mem_wdata;
                            ram_wstrb = mem_wstrb;
                            if (mem_we) begin
                                mem_done = 1'b1;
                            end else begin
                                owner_d    = OWN_MEM;
                                cnt_load_s = 1'b1;
                                state_d    = ST_BUSY;
                            end
                        end else begin
                            ram_addr   = if_addr;
                            owner_d    = OWN_IF;
                            cnt_load_s = 1'b1;
                            state_d    = ST_BUSY;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    cnt_dec_s = 1'b1;
                    // The RAM read cannot be cancelled, so a flush only hides its result.
                    if (flush && (owner_q == OWN_IF)) begin
                        squash_d = 1'b1;
                    end else begin
                        squash_d = squash_q;
                    end
                    if (cnt_last_s) begin
                        state_d  = ST_IDLE;
                        squash_d = 1'b0;
                        if (owner_q == OWN_MEM) begin
                            mem_done  = 1'b1;
                            mem_rdata = ram_rdata;
                        end else if (!squash_q && !flush) begin
                            if_done  = 1'b1;
                            if_rdata = ram_rdata;
                        end else begin
                            if_done = 1'b0;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            stall = (if_req && !if_done && !flush) || (mem_req && !mem_done);
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            squash_q     <= squash_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-ported unified data/instruction RAM. It shares the port between the IF-stage fetch requester and the MEM-stage load/store requester, and tracks the fixed RAM read latency. It returns read data and done pulses to the winner and drives the pipeline stall. It sits between the IF/MEM stage logic and the RAM macro; the MEM stage's load/store controls feed its MEM request side.

## Interface
Parameters:
- `LATENCY`, 2: RAM read latency in cycles, from `ram_en` to valid `ram_rdata`; legal range 1..15.
- `AW`, 32: address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `flush`  in  1  pipeline flush; squashes IF delivery.
- `if_req`  in  1  IF fetch request.
- `if_addr`  in  AW  fetch address.
- `if_done`  out  1  fetch data valid pulse.
- `if_rdata`  out  32  fetch data.
- `mem_req`  in  1  MEM access request.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_addr`  in  AW  load/store address.
- `mem_wdata`  in  32  store data.
- `mem_wstrb`  in  4  store byte enables.
- `mem_done`  out  1  access complete pulse.
- `mem_rdata`  out  32  load data.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  1  RAM write.
- `ram_addr`  out  AW  RAM address.
- `ram_wdata`  out  32  RAM write data.
- `ram_wstrb`  out  4  RAM byte enables.
- `ram_rdata`  in  32  RAM read data.
- `stall`  out  1  pipeline hold.

## Operation
- **FSM states**
  - IDLE: may issue.
  - BUSY: read outstanding; no issue.
- **Issue (IDLE only)**
  - Candidates: `mem_req`, and `if_req && !flush`.
  - One candidate: it wins.
  - Both: MEM wins unless `last_owner` = MEM, in which case IF wins. This alternation prevents starvation.
  - `last_owner` updates on every grant.
- **Grant**
  - Combinational in the same cycle: `ram_en` = 1.
  - `ram_addr`, `ram_we`, `ram_wdata` and `ram_wstrb` come from the winner; IF drives `ram_we` = 0 and `ram_wstrb` = 0.
- **Store grant**
  - `mem_done` = 1 in the grant cycle.
  - FSM stays IDLE.
- **Read grant**
  - Records `owner`, loads `cnt` = `LATENCY`, goes to BUSY.
- **BUSY**
  - `cnt` decrements each cycle.
  - When `cnt` = 1: response cycle. `ram_rdata` is passed to the owner's rdata and the owner's done = 1. Next state is IDLE.
- **Flush**
  - Flush during an IF read outstanding (any BUSY cycle, including the response cycle) sets `squash`.
  - With `squash` set, the response cycle still occurs but `if_done` stays 0. The RAM access cannot be cancelled.
  - `squash` clears on return to IDLE.
  - Flush has no effect on MEM-owned accesses.
- **Stall**
  - `stall` = (`if_req` && !`if_done` && !`flush`) || (`mem_req` && !`mem_done`).
- **Requester rules**
  - A requester holds req/addr/wdata stable until its done pulse.
  - Dropping req early is illegal, except IF on flush.
- **Reset**
  - State = IDLE, `cnt` = 0, `owner` = IF, `last_owner` = IF (MEM wins first contention), `squash` = 0.
  - All outputs are 0 while `rst` is high, including the combinational `ram_en` and the done signals.
  - Reset mid-BUSY abandons the read; no done pulse.

## Timing
- **Read**
  - Grant at T.
  - Done and rdata at T+LATENCY.
  - Earliest next issue at T+LATENCY+1.
  - Read throughput: 1 per LATENCY+1 cycles.
- **Store**
  - Done at T.
  - Back-to-back stores issue every cycle.
- `if_rdata` and `mem_rdata` are valid only with their done pulse; otherwise 0.
- **Counter:** width 4, never wraps. `cnt` is only loaded from IDLE, and its reload value equals `LATENCY`.
- **Simultaneous events**
  - Response cycle plus a new request: the new request waits one cycle (FSM is in BUSY).
  - `rst` plus anything: reset wins.

## Structure
- **Package `mem_arb_pkg`:**
  - state enum `{ST_IDLE, ST_BUSY}`;
  - owner encoding `OWN_IF = 1'b0`, `OWN_MEM = 1'b1`;
  - `CNT_W = 4`.
- **Sub-module `mem_lat_counter`:** load, decrement, and `last` flag. It is reusable by the future I-cache refill sequencer.

## Test plan
- **Isolated MEM load:** LATENCY=2, `mem_req` load at cycle 5, `ram_rdata` = 0xDEADBEEF at cycle 7. Require `ram_en` only at 5, `mem_done` plus `mem_rdata` = 0xDEADBEEF at 7, `stall` high at 5–6, and IDLE at 8.
- **Contention:**
  - Both requesting from reset: MEM granted first, IF second.
  - MEM re-requests while IF is still requesting: IF wins the next tie.
  - Check grant order M, I, M, I across 4 back-to-back reads.
- **Store burst:** 3 stores on consecutive cycles with `wstrb` 0x1, 0x3, 0xF. Require `ram_en`/`ram_we` and `mem_done` every cycle, FSM never BUSY, and `ram_wstrb` matching each store.
- **Flush during IF read:** IF read granted at T, flush at T+1. Require no `if_done`, `ram_en` low at T+1..T+2, and a new IF request accepted at T+3.
- **Reset mid-BUSY:** `rst` at T+1 of an IF read. Require no `if_done`, all outputs 0, and the first post-reset tie going to MEM.
- **LATENCY=1 instance:** read done at T+1 and next grant at T+2; repeat the contention scenario.
